qcs_fir_arb: RTL and testbench

//  Round-robin, packet-granular arbiter sharing one FIR datapath between NREQ complex I/Q sources.
//  - Grants one requester at a time and forwards its samples to the FIR input port (data_vld/data_i/data_q).
//  - Holds the grant until that requester's last-flagged sample.
//  - Sits between the upstream sample sources and the FIR; the FIR output monitor sees the resulting stream.

---
 rtl/qcs_fir_pkg.sv | 15 +
 rtl/qcs_fir_rr_pick.sv | 30 +++
 rtl/qcs_fir_arb.sv | 154 +++++++++++++++
 tb/tb_qcs_fir_arb.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qcs_fir_pkg.sv
// Shared types for the FIR arbiter slice: FSM state encoding and
// select-width helper used by the arbiter and the round-robin picker.
package qcs_fir_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      FLUSH
   } arb_state_e;

   function automatic int sel_w(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

endpackage

// File: rtl/qcs_fir_rr_pick.sv
// Combinational round-robin picker: first set request after ptr,
// searching ptr+1 .. ptr+NREQ modulo NREQ.
module qcs_fir_rr_pick
   import qcs_fir_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int SELW = sel_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [SELW-1:0] ptr,
   output logic            any,
   output logic [SELW-1:0] idx
);

   // Walk from the farthest offset down so the nearest hit wins.
   always_comb begin
      int k;
      k   = 0;
      any = 1'b0;
      idx = '0;
      for (int i = NREQ; i >= 1; i--) begin
         k = (int'(ptr) + i) % NREQ;
         if (req[k]) begin
            any = 1'b1;
            idx = SELW'(k);
         end
      end
   end

endmodule

// File: rtl/qcs_fir_arb.sv
// Packet-granular round-robin arbiter sharing one FIR among NREQ I/Q sources.
// Define QCS_FIR_ARB_FLUSH_EN to zero-flush the FIR delay line after each packet.
module qcs_fir_arb
   import qcs_fir_pkg::*;
#(
   parameter int DW    = 16,
   parameter int NREQ  = 4,
   parameter int NTAPS = 16,
   localparam int SELW = sel_w(NREQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_vld,
   input  logic [NREQ-1:0]      req_last,
   input  logic [NREQ*DW-1:0]   req_i,
   input  logic [NREQ*DW-1:0]   req_q,
   output logic [NREQ-1:0]      req_rdy,
   output logic                 fir_vld,
   output logic [DW-1:0]        fir_i,
   output logic [DW-1:0]        fir_q,
   output logic                 fir_sop,
   output logic [SELW-1:0]      fir_sel,
   output logic                 busy
);

   arb_state_e      state_q, state_d;
   logic [SELW-1:0] gnt_q, gnt_d;
   logic [SELW-1:0] ptr_q, ptr_d;
   logic            first_q, first_d;
   logic            fir_vld_q, fir_vld_d;
   logic [DW-1:0]   fir_i_q, fir_i_d;
   logic [DW-1:0]   fir_q_q, fir_q_d;
   logic            fir_sop_q, fir_sop_d;
   logic [SELW-1:0] fir_sel_q, fir_sel_d;

   logic            pick_any;
   logic [SELW-1:0] pick_idx;
   logic            xfer;
   logic [DW-1:0]   s_i, s_q;

`ifdef QCS_FIR_ARB_FLUSH_EN
   localparam int CW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
`endif

   qcs_fir_rr_pick #(.NREQ(NREQ)) u_pick (
      .req (req_vld),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign xfer = (state_q == GRANT) && req_vld[gnt_q];
   assign s_i  = req_i[int'(gnt_q)*DW +: DW];
   assign s_q  = req_q[int'(gnt_q)*DW +: DW];

   // Ready is decoded from registers only, never from req_vld.
   always_comb begin
      req_rdy = '0;
      if (state_q == GRANT) req_rdy[gnt_q] = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      ptr_d     = ptr_q;
      first_d   = first_q;
      fir_vld_d = 1'b0;
      fir_i_d   = '0;
      fir_q_d   = '0;
      fir_sop_d = 1'b0;
      fir_sel_d = fir_sel_q;
`ifdef QCS_FIR_ARB_FLUSH_EN
      cnt_d     = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               gnt_d   = pick_idx;
               ptr_d   = pick_idx;
               first_d = 1'b1;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (xfer) begin
               fir_vld_d = 1'b1;
               fir_i_d   = s_i;
               fir_q_d   = s_q;
               fir_sop_d = first_q;
               fir_sel_d = gnt_q;
               first_d   = 1'b0;
               if (req_last[gnt_q]) begin
`ifdef QCS_FIR_ARB_FLUSH_EN
                  state_d = FLUSH;
                  cnt_d   = CW'(NTAPS - 1);
`else
                  state_d = IDLE;
`endif
               end
            end
         end
         FLUSH: begin
`ifdef QCS_FIR_ARB_FLUSH_EN
            fir_vld_d = 1'b1;
            fir_sel_d = gnt_q;
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - CW'(1);
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         ptr_q     <= SELW'(NREQ - 1);
         first_q   <= 1'b0;
         fir_vld_q <= 1'b0;
         fir_i_q   <= '0;
         fir_q_q   <= '0;
         fir_sop_q <= 1'b0;
         fir_sel_q <= '0;
`ifdef QCS_FIR_ARB_FLUSH_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         ptr_q     <= ptr_d;
         first_q   <= first_d;
         fir_vld_q <= fir_vld_d;
         fir_i_q   <= fir_i_d;
         fir_q_q   <= fir_q_d;
         fir_sop_q <= fir_sop_d;
         fir_sel_q <= fir_sel_d;
`ifdef QCS_FIR_ARB_FLUSH_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign fir_vld = fir_vld_q;
   assign fir_i   = fir_i_q;
   assign fir_q   = fir_q_q;
   assign fir_sop = fir_sop_q;
   assign fir_sel = fir_sel_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_qcs_fir_arb.sv
// Directed bench for qcs_fir_arb: vector table plus hand sequences
// for bubbles, reset mid-packet, round-robin order and flush.
module tb_qcs_fir_arb;

   localparam int DW = 16;
   localparam int NREQ = 4;
   localparam int NTAPS = 16;
`ifdef QCS_FIR_ARB_FLUSH_EN
   localparam logic FL = 1'b1;
`else
   localparam logic FL = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                reset;
   logic [NREQ-1:0]     req_vld;
   logic [NREQ-1:0]     req_last;
   logic [NREQ*DW-1:0]  req_i;
   logic [NREQ*DW-1:0]  req_q;
   logic [NREQ-1:0]     req_rdy;
   logic                fir_vld;
   logic [DW-1:0]       fir_i;
   logic [DW-1:0]       fir_q;
   logic                fir_sop;
   logic [1:0]          fir_sel;
   logic                busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   qcs_fir_arb #(.DW(DW), .NREQ(NREQ), .NTAPS(NTAPS)) dut (
      .clk      (clk),
      .reset    (reset),
      .req_vld  (req_vld),
      .req_last (req_last),
      .req_i    (req_i),
      .req_q    (req_q),
      .req_rdy  (req_rdy),
      .fir_vld  (fir_vld),
      .fir_i    (fir_i),
      .fir_q    (fir_q),
      .fir_sop  (fir_sop),
      .fir_sel  (fir_sel),
      .busy     (busy)
   );

   typedef struct {
      logic [3:0]  vld;
      logic [3:0]  last;
      logic [15:0] i0;
      logic [15:0] q0;
      logic [3:0]  rdy;
      logic        fv;
      logic        sop;
      logic [1:0]  sel;
      logic [15:0] fi;
      logic [15:0] fq;
      logic        bsy;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] last,
                               input logic [15:0] i0, input logic [15:0] q0,
                               input logic [3:0] rdy, input logic fv,
                               input logic sop, input logic [15:0] fi,
                               input logic [15:0] fq, input logic bsy);
      vec_t v;
      v.vld = vld; v.last = last; v.i0 = i0; v.q0 = q0;
      v.rdy = rdy; v.fv = fv; v.sop = sop; v.sel = 2'd0;
      v.fi = fi; v.fq = fq; v.bsy = bsy;
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req_vld = '0; req_last = '0; req_i = '0; req_q = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sops;
      int idle;
      int cnt[4];
      logic [3:0] xp;
      logic [15:0] v;
      int exp_order[5];
      bit got;

      reset = 1'b1;
      req_vld = '0; req_last = '0; req_i = '0; req_q = '0;

      // Idle after reset, then a 3-sample packet from requester 0.
      for (int k = 0; k < 10; k++)
         tbl[k] = mk(4'h0, 4'h0, 16'd0, 16'd0, 4'h0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
      tbl[10] = mk(4'h1, 4'h0, 16'd1, 16'd2, 4'h1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
      tbl[11] = mk(4'h1, 4'h0, 16'd1, 16'd2, 4'h1, 1'b1, 1'b1, 16'd1, 16'd2, 1'b1);
      tbl[12] = mk(4'h1, 4'h0, 16'd3, 16'd4, 4'h1, 1'b1, 1'b0, 16'd3, 16'd4, 1'b1);
      tbl[13] = mk(4'h1, 4'h1, 16'd5, 16'd6, 4'h0, 1'b1, 1'b0, 16'd5, 16'd6, FL);
      tbl[14] = mk(4'h0, 4'h0, 16'd0, 16'd0, 4'h0, FL, 1'b0, 16'd0, 16'd0, FL);

      do_reset();
      chk("rst_vld", 32'(fir_vld), 32'd0);
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         req_vld  = tbl[n].vld;
         req_last = tbl[n].last;
         req_i    = '0;
         req_q    = '0;
         req_i[15:0] = tbl[n].i0;
         req_q[15:0] = tbl[n].q0;
         edge_sample();
         chk($sformatf("v%0d_rdy", n), 32'(req_rdy), 32'(tbl[n].rdy));
         chk($sformatf("v%0d_vld", n), 32'(fir_vld), 32'(tbl[n].fv));
         chk($sformatf("v%0d_sop", n), 32'(fir_sop), 32'(tbl[n].sop));
         chk($sformatf("v%0d_bsy", n), 32'(busy), 32'(tbl[n].bsy));
         if (tbl[n].fv) begin
            chk($sformatf("v%0d_i", n), 32'(fir_i), 32'(tbl[n].fi));
            chk($sformatf("v%0d_q", n), 32'(fir_q), 32'(tbl[n].fq));
            chk($sformatf("v%0d_sel", n), 32'(fir_sel), 32'(tbl[n].sel));
         end
      end

      // All four hold 2-sample packets: order 0,1,2,3,0, one idle between.
      exp_order = '{0, 1, 2, 3, 0};
      do_reset();
      sops = 0; idle = 0; xp = '0;
      cnt = '{0, 0, 0, 0};
      for (int c = 0; c < 400 && sops < 5; c++) begin
         @(negedge clk);
         if (fir_sop) begin
            if (sops > 0) chk("rr_gap", 32'(idle), 32'd1);
            chk("rr_sel", 32'(fir_sel), 32'(exp_order[sops]));
            chk("rr_i", 32'(fir_i), 32'(exp_order[sops] * 16 + 1));
            idle = 0;
            sops++;
         end else if (!busy) begin
            idle++;
         end
         for (int k = 0; k < 4; k++)
            if (xp[k]) cnt[k] = (cnt[k] == 1) ? 0 : 1;
         req_vld = 4'hF;
         for (int k = 0; k < 4; k++) begin
            v = 16'(k * 16 + cnt[k] + 1);
            req_last[k] = (cnt[k] == 1);
            req_i[k*16 +: 16] = v;
            req_q[k*16 +: 16] = 16'h0 - v;
         end
         xp = req_vld & req_rdy;
      end
      chk("rr_count", 32'(sops), 32'd5);

      // Requester 2 bubbles for 3 cycles while requester 1 waits.
      do_reset();
      @(negedge clk);
      req_vld = 4'b0100;
      req_i[32 +: 16] = 16'h21; req_q[32 +: 16] = 16'h22;
      edge_sample();
      chk("bub_rdy0", 32'(req_rdy), 32'h4);
      @(negedge clk);
      req_vld = 4'b0110;
      req_i[16 +: 16] = 16'h11; req_q[16 +: 16] = 16'h12;
      edge_sample();
      chk("bub_s1_vld", 32'(fir_vld), 32'd1);
      chk("bub_s1_i", 32'(fir_i), 32'h21);
      chk("bub_s1_sel", 32'(fir_sel), 32'd2);
      @(negedge clk);
      req_vld = 4'b0010;
      for (int b = 0; b < 3; b++) begin
         edge_sample();
         chk("bub_vld", 32'(fir_vld), 32'd0);
         chk("bub_rdy", 32'(req_rdy), 32'h4);
      end
      @(negedge clk);
      req_vld = 4'b0110; req_last = 4'b0100;
      req_i[32 +: 16] = 16'h23; req_q[32 +: 16] = 16'h24;
      edge_sample();
      chk("bub_s2_i", 32'(fir_i), 32'h23);
      chk("bub_s2_sop", 32'(fir_sop), 32'd0);
      chk("bub_s2_rdy", 32'(req_rdy), 32'h0);
      @(negedge clk);
      req_vld = 4'b0010; req_last = 4'b0000;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         edge_sample();
         if (fir_sop) got = 1'b1;
      end
      chk("bub_next_got", 32'(got), 32'd1);
      if (got) begin
         chk("bub_next_sel", 32'(fir_sel), 32'd1);
         chk("bub_next_i", 32'(fir_i), 32'h11);
      end

      // Reset on the 2nd sample; pointer returns to favour requester 0.
      do_reset();
      @(negedge clk);
      req_vld = 4'b1001;
      req_i[0 +: 16] = 16'h01; req_i[48 +: 16] = 16'h31;
      edge_sample();
      chk("rst_gnt0", 32'(req_rdy), 32'h1);
      edge_sample();
      chk("rst_s1", 32'(fir_i), 32'h01);
      @(negedge clk);
      req_i[0 +: 16] = 16'h02;
      reset = 1'b1;
      edge_sample();
      chk("rst_mid_vld", 32'(fir_vld), 32'd0);
      chk("rst_mid_i", 32'(fir_i), 32'd0);
      chk("rst_mid_sop", 32'(fir_sop), 32'd0);
      chk("rst_mid_sel", 32'(fir_sel), 32'd0);
      chk("rst_mid_bsy", 32'(busy), 32'd0);
      chk("rst_mid_rdy", 32'(req_rdy), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      req_i[0 +: 16] = 16'h01;
      edge_sample();
      chk("rst_regnt", 32'(req_rdy), 32'h1);

      // Single-sample packet (7,-7), then flush or straight to idle.
      do_reset();
      @(negedge clk);
      req_vld = 4'b0001; req_last = 4'b0001;
      req_i[0 +: 16] = 16'd7; req_q[0 +: 16] = 16'hFFF9;
      edge_sample();
      edge_sample();
      chk("one_vld", 32'(fir_vld), 32'd1);
      chk("one_sop", 32'(fir_sop), 32'd1);
      chk("one_i", 32'(fir_i), 32'd7);
      chk("one_q", 32'(fir_q), 32'hFFF9);
      @(negedge clk);
      req_vld = '0; req_last = '0;
      if (FL) begin
         for (int t = 0; t < NTAPS; t++) begin
            edge_sample();
            chk($sformatf("fl%0d_vld", t), 32'(fir_vld), 32'd1);
            chk($sformatf("fl%0d_iq", t), 32'({fir_i, fir_q}), 32'd0);
            chk($sformatf("fl%0d_rdy", t), 32'(req_rdy), 32'h0);
         end
      end
      edge_sample();
      chk("one_end_vld", 32'(fir_vld), 32'd0);
      chk("one_end_bsy", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
